// File: rtl/word_pair_packer.sv
// word_pair_packer: packs RATIO consecutive IN_W-bit words into one wide beat
// with a contiguous lane-keep mask. A partial beat is forced out by an idle
// timeout or an explicit flush.
module word_pair_packer #(
    parameter int IN_W    = 32,
    parameter int RATIO   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  flush,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [IN_W*RATIO-1:0] out_data,
    output logic [RATIO-1:0]      out_keep
);

    localparam int CNT_W  = $clog2(RATIO + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_inc;
    logic [IDLE_W-1:0]       idle;
    logic [IN_W*RATIO-1:0]   data_q;
    logic [RATIO-1:0]        keep_q;
    logic                    accept;
    logic                    timed_out;

    assign accept    = in_vld && in_rdy;
    assign count_inc = count + 1'b1;
    assign timed_out = (idle == IDLE_W'(TIMEOUT));
    assign out_data  = data_q;
    assign out_keep  = keep_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fill until full, timed out or flushed; hold until taken
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && (count_inc == CNT_W'(RATIO))) begin
                    state_nxt = HOLD;
                end else if ((count != '0) && (flush || (timed_out && !accept))) begin
                    // a word accepted together with flush joins the partial beat
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Outputs decoded from registered state; in_rdy held low during reset
    always_comb begin
        out_vld = (state == HOLD);
        in_rdy  = (state == FILL) && !rst;
    end

    // Lane data, keep mask, lane count and idle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            keep_q <= '0;
            count  <= '0;
            idle   <= '0;
        end else if (state == HOLD) begin
            if (out_rdy) begin
                data_q <= '0;
                keep_q <= '0;
                count  <= '0;
                idle   <= '0;
            end
        end else begin
            if (accept) begin
                for (int unsigned k = 0; k < RATIO; k++) begin
                    if (CNT_W'(k) == count) begin
                        data_q[k*IN_W +: IN_W] <= in_data;
                        keep_q[k]              <= 1'b1;
                    end
                end
                count <= count_inc;
                idle  <= '0;
            end else if (count == '0) begin
                idle <= '0;
            end else if (!timed_out) begin
                idle <= idle + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_pair_packer.sv
// Testbench for word_pair_packer: directed vectors with a scoreboard queue of
// expected beats, plus a randomized stream checked for word order and count.
module tb_word_pair_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_data;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [63:0] out_data;
    logic [1:0]  out_keep;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  keep;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] word_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          kept_words = 0;
    bit          random_mode = 0;
    bit          rand_run = 0;

    word_pair_packer #(
        .IN_W   (32),
        .RATIO  (2),
        .TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .flush   (flush),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_data(out_data),
        .out_keep(out_keep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [1:0] k);
        beat_t b;
        b.data = d;
        b.keep = k;
        exp_q.push_back(b);
    endtask

    // Hold the word until accepted; returns 1 time unit after the accepting edge
    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        in_vld  = 1'b1;
        in_data = d;
        while (1) begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 200) begin
                fail_now("in_rdy_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Monitor: checks every accepted beat
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (out_vld && out_rdy) begin
                check("keep_nonzero", 64'(out_keep != 2'b00), 64'd1);
                check("keep_contiguous", 64'((out_keep & (out_keep + 2'b01)) == 2'b00), 64'd1);
                if (random_mode) begin
                    kept_words += $countones(out_keep);
                    for (int k = 0; k < 2; k++) begin
                        if (out_keep[k]) begin
                            if (word_q.size() == 0) fail_now("word_q_underflow");
                            else check("rand_lane_word", 64'(out_data[k*32 +: 32]), 64'(word_q.pop_front()));
                        end else begin
                            check("rand_unused_lane", 64'(out_data[k*32 +: 32]), 64'd0);
                        end
                    end
                end else if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_keep", 64'(out_keep), 64'(b.keep));
                end
            end
        end
    end

    // Random out_rdy / flush during the stream test
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_run) begin
                out_rdy = ($urandom_range(0, 3) != 0);
                flush   = ($urandom_range(0, 15) == 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_vld = 1'b0; in_data = '0; flush = 1'b0; out_rdy = 1'b1;
        #1;
        check("reset_out_vld", 64'(out_vld), 64'd0);
        check("reset_out_keep", 64'(out_keep), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_in_rdy", 64'(in_rdy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Two back-to-back words -> one full beat
        push_beat(64'h22222222_11111111, 2'b11);
        send_word(32'h11111111);
        send_word(32'h22222222);
        check("full_out_vld", 64'(out_vld), 64'd1);
        check("full_in_rdy_low", 64'(in_rdy), 64'd0);
        tick();
        check("full_drain_vld", 64'(out_vld), 64'd0);
        check("full_in_rdy_back", 64'(in_rdy), 64'd1);

        // Idle timeout: accept on cycle 0 -> out_vld on cycle 17
        push_beat(64'h00000000_DEADBEEF, 2'b01);
        send_word(32'hDEADBEEF);
        n = 0;
        while (!out_vld && n < 40) begin
            tick();
            n++;
        end
        check("timeout_latency", 64'(n), 64'd17);
        tick();
        check("timeout_drained", 64'(out_vld), 64'd0);

        // Flush three cycles after a single word
        push_beat(64'h00000000_A5A5A5A5, 2'b01);
        send_word(32'hA5A5A5A5);
        tick();
        tick();
        pulse_flush();
        check("flush_out_vld", 64'(out_vld), 64'd1);
        tick();

        // Flush with empty lanes: nothing emitted
        pulse_flush();
        check("flush_empty_0", 64'(out_vld), 64'd0);
        tick();
        check("flush_empty_1", 64'(out_vld), 64'd0);

        // Backpressure: full beat held while upstream waits
        out_rdy = 1'b0;
        push_beat(64'h66666666_55555555, 2'b11);
        send_word(32'h55555555);
        send_word(32'h66666666);
        in_vld  = 1'b1;
        in_data = 32'h33333333;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_vld", 64'(out_vld), 64'd1);
            check("bp_in_rdy", 64'(in_rdy), 64'd0);
            check("bp_data", out_data, 64'h66666666_55555555);
            check("bp_keep", 64'(out_keep), 64'd3);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        check("bp_release_vld", 64'(out_vld), 64'd0);
        check("bp_release_rdy", 64'(in_rdy), 64'd1);
        tick();
        in_vld = 1'b0;
        check("bp_partial_not_emitted", 64'(out_vld), 64'd0);
        push_beat(64'h00000000_33333333, 2'b01);
        pulse_flush();
        check("bp_flush_vld", 64'(out_vld), 64'd1);
        tick();
        tick();
        check("directed_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random stream of 1000 words with random out_rdy / flush
        random_mode = 1;
        kept_words  = 0;
        rand_run    = 1;
        for (int w = 0; w < 1000; w++) begin
            logic [31:0] d;
            int g;
            d = $urandom();
            word_q.push_back(d);
            send_word(d);
            g = ($urandom_range(0, 49) == 0) ? 20 : $urandom_range(0, 3);
            repeat (g) tick();
        end
        rand_run = 0;
        @(posedge clk);
        #2;
        out_rdy = 1'b1;
        flush   = 1'b0;
        repeat (40) tick();
        random_mode = 0;
        check("rand_popcount_sum", 64'(kept_words), 64'd1000);
        check("rand_words_left", 64'(word_q.size()), 64'd0);

        // Asynchronous reset while holding a partial beat
        out_rdy = 1'b0;
        send_word(32'h77777777);
        pulse_flush();
        check("arst_hold_vld", 64'(out_vld), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_out_vld", 64'(out_vld), 64'd0);
        check("arst_out_keep", 64'(out_keep), 64'd0);
        check("arst_out_data", out_data, 64'd0);
        check("arst_in_rdy", 64'(in_rdy), 64'd0);
        tick();
        rst     = 1'b0;
        out_rdy = 1'b1;
        tick();
        push_beat(64'h99999999_88888888, 2'b11);
        send_word(32'h88888888);
        send_word(32'h99999999);
        repeat (3) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
